// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit common-anode scan controller with frame snapshot and guard time
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   snap;
    logic [3:0]    snap_dp;
    logic          slot_end, frame_end, in_guard;
    logic [3:0]    cur_digit;
    logic [3:0]    an_d, bcd_d;
    logic          dp_d;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end
    endgenerate

    always_comb begin
        slot_end  = (cnt == CNT_MAX);
        frame_end = slot_end && (idx == 2'd3);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        idx_nxt   = slot_end ? idx + 2'd1 : idx;
        cur_digit = snap[{idx, 2'b00} +: 4];
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    logic [3:0] blank;
    always_comb begin
        blank[3] = (snap[15:12] == 4'h0);
        blank[2] = blank[3] && (snap[11:8] == 4'h0);
        blank[1] = blank[2] && (snap[7:4] == 4'h0);
        blank[0] = 1'b0;
    end
`endif

    always_comb begin
        an_d  = 4'b1111;
        bcd_d = 4'hF;
        dp_d  = 1'b1;
        if (!in_guard) begin
            an_d  = ~(4'b0001 << idx);
            bcd_d = cur_digit;
            dp_d  = ~snap_dp[idx];
`ifdef SEG_SCAN_LZB_EN
            // Keep the anode on for a blanked digit whose decimal point is lit.
            if (blank[idx]) begin
                bcd_d = 4'hF;
                if (!snap_dp[idx]) begin
                    an_d = 4'b1111;
                    dp_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            snap       <= 16'h0000;
            snap_dp    <= 4'b0000;
            an         <= 4'b1111;
            bcd        <= 4'hF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            if (frame_end) begin
                snap    <= digits;
                snap_dp <= dp_mask;
            end
            an         <= an_d;
            bcd        <= bcd_d;
            dp         <= dp_d;
            // Registered so the pulse coincides with the frame-boundary state.
            frame_tick <= (cnt_nxt == CNT_MAX) && (idx_nxt == 2'd3);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

    localparam int R = 4;
    localparam int G = 1;

`ifdef SEG_SCAN_LZB_EN
    localparam logic [63:0] Z_AN  = 64'hFEEE_FFFF_FFFF_FFFF;
    localparam logic [63:0] Z_BCD = 64'hF000_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] Z_AN  = 64'hFEEE_FDDD_FBBB_F777;
    localparam logic [63:0] Z_BCD = 64'hF000_F000_F000_F000;
`endif
    localparam logic [63:0] ALL_AN = 64'hFEEE_FDDD_FBBB_F777;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  bcd, an;
    logic        dp, frame_tick;

    int tests = 0;
    int fails = 0;

    seg_scan_mux #(.REFRESH_DIV(R), .GUARD(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .bcd        (bcd),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Reference model: global cycle count since reset gives slot and position directly.
    int          k;
    int          slot, pos;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic [3:0]  e_an, e_bcd;
    logic        e_dp, e_tick;
    logic        blanked;
    bit          m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            k = 0; m_snap = 16'h0; m_dp = 4'h0;
            e_an = 4'hF; e_bcd = 4'hF; e_dp = 1'b1; e_tick = 1'b0;
            m_valid = 1;
        end else begin
            slot = (k / R) % 4;
            pos  = k % R;
            blanked = 1'b0;
`ifdef SEG_SCAN_LZB_EN
            blanked = (slot != 0) && ((m_snap >> (4 * slot)) == 16'h0);
`endif
            if (pos < G) begin
                e_an = 4'hF; e_bcd = 4'hF; e_dp = 1'b1;
            end else if (blanked) begin
                e_bcd = 4'hF;
                e_an  = m_dp[slot] ? ~(4'b0001 << slot) : 4'hF;
                e_dp  = !m_dp[slot];
            end else begin
                e_an  = ~(4'b0001 << slot);
                e_bcd = 4'((m_snap >> (4 * slot)) & 16'hF);
                e_dp  = !m_dp[slot];
            end
            if (k % (4 * R) == 4 * R - 1) begin
                m_snap = digits;
                m_dp   = dp_mask;
            end
            k++;
            e_tick = (k % (4 * R) == 4 * R - 1);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_an", k, an, e_an);
            chk("model_bcd", k, bcd, e_bcd);
            chk("model_dp", k, {3'b0, dp}, {3'b0, e_dp});
            chk("model_tick", k, {3'b0, frame_tick}, {3'b0, e_tick});
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            tests++; fails++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles", n);
        end
    endtask

    task automatic sync_frame();
        wait_tick();
        @(negedge clk);
    endtask

    task automatic capture(input string name, input logic [63:0] ean, input logic [63:0] ebcd,
                           input logic [15:0] edp, input logic [15:0] chg_val, input int chg_at);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk({name, "_an"}, i, an, ean[63-4*i -: 4]);
            chk({name, "_bcd"}, i, bcd, ebcd[63-4*i -: 4]);
            chk({name, "_dp"}, i, {3'b0, dp}, {3'b0, edp[15-i]});
            if (i == chg_at) digits = chg_val;
        end
    endtask

    initial begin
        int period;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_an", i, an, 4'hF);
            chk("rst_bcd", i, bcd, 4'hF);
            chk("rst_dp", i, {3'b0, dp}, 4'h1);
            chk("rst_tick", i, {3'b0, frame_tick}, 4'h0);
        end
        reset = 1'b0;

        capture("first", Z_AN, Z_BCD, 16'hFFFF, 16'h0, -1);
        capture("f1234", ALL_AN, 64'hF444_F333_F222_F111, 16'hFFFF, 16'h0, -1);

        wait_tick();
        period = 0;
        do begin
            @(negedge clk);
            period++;
        end while (!frame_tick && period < 40);
        chk("tick_period", 0, 4'(period), 4'(16));

        @(negedge clk);
        capture("chg", ALL_AN, 64'hF444_F333_F222_F111, 16'hFFFF, 16'h5678, 5);
        capture("f5678", ALL_AN, 64'hF888_F777_F666_F555, 16'hFFFF, 16'h0, -1);

        digits = 16'h1234; dp_mask = 4'b0100;
        sync_frame();
        capture("dp", ALL_AN, 64'hF444_F333_F222_F111, 16'hFF8F, 16'h0, -1);
        dp_mask = 4'b0000;

`ifdef SEG_SCAN_LZB_EN
        digits = 16'h0047;
        sync_frame();
        capture("lzb47", 64'hFEEE_FDDD_FFFF_FFFF, 64'hF777_F444_FFFF_FFFF, 16'hFFFF, 16'h0, -1);
        digits = 16'h0000;
        sync_frame();
        capture("lzb0", 64'hFEEE_FFFF_FFFF_FFFF, 64'hF000_FFFF_FFFF_FFFF, 16'hFFFF, 16'h0, -1);
        digits = 16'h0405;
        sync_frame();
        capture("lzb405", 64'hFEEE_FDDD_FBBB_FFFF, 64'hF555_F000_F444_FFFF, 16'hFFFF, 16'h0, -1);
        digits = 16'h1234;
`endif

        sync_frame();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_an", 0, an, 4'hF);
        chk("midrst_bcd", 0, bcd, 4'hF);
        chk("midrst_dp", 0, {3'b0, dp}, 4'h1);
        chk("midrst_tick", 0, {3'b0, frame_tick}, 4'h0);
        reset = 1'b0;
        capture("post_rst", Z_AN, Z_BCD, 16'hFFFF, 16'h0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scan controller for the four-digit common-anode display of the stopwatch. It takes four packed BCD digits from the counter chain and drives one digit at a time. For the selected digit it presents the 4-bit BCD code to the downstream BCD-to-7-segment decoder and drives the matching active-low anode. It sits between the stopwatch counter and the segment decoder. It adds a frame snapshot (no tearing), an anti-ghosting dead time, and decimal-point control.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot. At 100 MHz this gives 1 kHz per digit and 250 Hz per frame. Legal range is ≥ 2.
- `GUARD`, 16: cycles at the start of each slot during which all anodes are off. Legal range is 0 ≤ GUARD < REFRESH_DIV.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `digits`  in  16  packed BCD digits. [3:0] is digit 0 (rightmost, an[0]); [15:12] is digit 3 (leftmost).
- `dp_mask`  in  4  decimal point request per digit (1 = lit). Bit i maps to digit i.
- `bcd`  out  4  BCD code to the segment decoder. 4'hF means blank; the decoder maps codes 10–15 to all segments off.
- `an`  out  4  anode enables, active-low.
- `dp`  out  1  decimal point cathode, active-low.
- `frame_tick`  out  1  one-cycle pulse on the cycle the snapshot register loads.

## Operation
- Slot counter `cnt` counts 0..REFRESH_DIV-1 and then wraps to 0. On the wrap, digit index `idx` (2 bits) increments mod 4, in the order 0→1→2→3→0.
- Snapshot register `snap` (16 bits) loads `digits` on the cycle where cnt==REFRESH_DIV-1 and idx==3. This is the frame boundary. `frame_tick` is 1 on that same cycle.
- `snap` loads `dp_mask` alongside `digits` as `snap_dp`. Input changes mid-frame have no visible effect until the next frame.
- Output registers update every cycle from the current (`cnt`, `idx`, `snap`, `snap_dp`):
  - When cnt < GUARD: an=4'b1111, bcd=4'hF, dp=1.
  - Otherwise: an = ~(4'b0001 << idx), bcd = snap digit idx, dp = ~snap_dp[idx].
- BCD values 10–15 in `digits` are passed through unchanged; the decoder blanks them.
- Reset: cnt=0, idx=0, snap=16'h0000, snap_dp=4'b0000, an=4'b1111, bcd=4'hF, dp=1, frame_tick=0.
- The first frame after reset therefore shows 0000 with no decimal points. The first snapshot of live inputs occurs at the end of that frame.
- Reset asserted mid-slot or mid-frame aborts immediately. The next cycle shows the reset values, and scanning restarts at digit 0, cnt=0.

## Timing
- Output latency is 1 cycle from the (`cnt`, `idx`) state to `an`/`bcd`/`dp`. All outputs are registered, with no combinational path from inputs.
- First cycle after reset release: the state is cnt=0, idx=0. The outputs from that state appear one cycle later.
- Each slot is exactly REFRESH_DIV cycles: GUARD cycles dark, then REFRESH_DIV-GUARD cycles lit. A frame is 4·REFRESH_DIV cycles.
- `frame_tick` period is exactly 4·REFRESH_DIV cycles. The `snap` value used by digit 0 of the next frame is the one loaded on the tick cycle.
- With GUARD=0, no dark cycles occur and an anode is always driven.

## Configuration
- `SEG_SCAN_LZB_EN` defined enables leading-zero blanking, evaluated on `snap`.
  - Digit i (i = 3, 2, 1) is blanked when it and all higher digits are 4'h0.
  - A blanked digit gets an bit forced to 1, bcd=4'hF and dp=1, unless snap_dp[i]=1. In that case the anode stays on, bcd=4'hF and dp=0, so the point stays visible.
  - Digit 0 is never blanked.
- `SEG_SCAN_LZB_EN` undefined: all four digits are always displayed, including leading zeros.

## Test plan
- Reset held 5 cycles, with digits=16'h1234 -> an=4'b1111, bcd=4'hF, dp=1, frame_tick=0 throughout. After release, the first lit frame shows 0,0,0,0.
- REFRESH_DIV=4, GUARD=1, digits=16'h1234 held -> from the second frame, per slot: 1 cycle an=1111, then 3 cycles of an=1110/bcd=4, an=1101/bcd=3, an=1011/bcd=2, an=0111/bcd=1 in turn. frame_tick pulses every 16 cycles.
- Same config, digits changed from 16'h1234 to 16'h5678 while idx=1 -> the remaining slots of that frame still show 3,2,1. The next frame shows 8,7,6,5.
- dp_mask=4'b0100, digits=16'h1234 -> dp=0 only during the lit cycles of slot 2 (an=1011). dp=1 during guard cycles and all other slots.
- `SEG_SCAN_LZB_EN` defined:
  - digits=16'h0047 -> an[3] and an[2] stay 1 in their slots.
  - digits=16'h0000 -> only digit 0 lit, showing 0.
  - digits=16'h0405 -> digit 3 blanked, digit 1 shows 0.
- Reset pulsed for 1 cycle during slot 2 -> next cycle has reset outputs, and the following slot sequence restarts at digit 0 with a full REFRESH_DIV length.
